// File: rtl/rip_load_store_unit.sv
// rip_load_store_unit
//   Load/store unit between an RV32I core and a single-port word memory.
//   It accepts one access at a time. Each access is legality-checked,
//   issued once to memory, and answered with a one-cycle response pulse.
//   Loads are sign- or zero-extended from the addressed lane.
//   Stores are replicated across lanes, and byte enables select the lanes.
//
// Ports
//   clk, rstn            clock; synchronous active-low reset
//   req_valid/req_ready  core request handshake (ready only while idle)
//   req_we               1 = store, 0 = load
//   req_funct3           RV32I width code (B/H/W, BU/HU)
//   req_addr             byte address
//   req_wdata            right-aligned store data
//   resp_valid           one-cycle completion pulse
//   resp_rdata           extended load data (0 for stores and errors)
//   resp_err             misaligned access or illegal funct3
//   mem_we/mem_re        byte write enables / read request (one cycle)
//   mem_addr             word address (byte address >> 2)
//   mem_din/mem_dout     lane-aligned write data / read data
//   mem_busy             memory cannot accept or complete this cycle
module rip_load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [3:0]            mem_we,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  input  logic                  mem_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic                    we_q, we_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic                    req_legal;
  logic [3:0]              store_be;
  logic [31:0]             store_data;
  logic [7:0]              load_byte;
  logic [15:0]             load_half;
  logic [31:0]             load_ext;

  // Legality is judged on the incoming request, so an illegal access
  // jumps straight to the response and never reaches the memory port.
  always_comb begin
    req_legal = 1'b0;
    case (req_funct3)
      3'b000:  req_legal = 1'b1;
      3'b001:  req_legal = ~req_addr[0];
      3'b010:  req_legal = (req_addr[1:0] == 2'b00);
      3'b100:  req_legal = ~req_we;
      3'b101:  req_legal = ~req_we & ~req_addr[0];
      default: req_legal = 1'b0;
    endcase
  end

  // Only legal stores get here, so funct3[1:0] is 00, 01 or 10.
  always_comb begin
    store_be   = 4'b1111;
    store_data = wdata_q[31:0];
    case (funct3_q[1:0])
      2'b00: begin
        store_be   = 4'b0001 << addr_q[1:0];
        store_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        store_be   = 4'b0011 << {addr_q[1], 1'b0};
        store_data = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    load_byte = mem_dout[{addr_q[1:0], 3'b000} +: 8];
    load_half = addr_q[1] ? mem_dout[31:16] : mem_dout[15:0];
    load_ext  = mem_dout[31:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_ext = {{16{load_half[15]}}, load_half};
      3'b100:  load_ext = {24'h0, load_byte};
      3'b101:  load_ext = {16'h0, load_half};
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_we     = 4'b0000;
    mem_re     = 1'b0;
    mem_addr   = '0;
    mem_din    = '0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          err_d    = ~req_legal;
          state_d  = req_legal ? S_ISSUE : S_RESP;
        end
      end
      S_ISSUE: begin
        mem_addr = addr_q >> 2;
        if (we_q) mem_din = DATA_WIDTH'(store_data);
        // The strobe fires only in a cycle where memory can take it.
        if (!mem_busy) begin
          if (we_q) mem_we = store_be;
          else      mem_re = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        mem_addr = addr_q >> 2;
        if (!mem_busy) begin
          if (!we_q) rdata_d = DATA_WIDTH'(load_ext);
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_rip_load_store_unit.sv
// tb_rip_load_store_unit
//   Bench for rip_load_store_unit. It includes a word memory responder that
//   stays busy for 3 cycles per access. It runs a directed vector table,
//   back-to-back and reset sequences, and randomized accesses. The random
//   accesses are predicted by a byte-addressed reference memory.
module tb_rip_load_store_unit;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [3:0]  mem_we;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_busy;

  int checks = 0;
  int errors = 0;

  rip_load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout),
    .mem_busy   (mem_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: 64 words, 3 busy cycles after each accepted strobe.
  // stall_busy adds extra busy cycles in front of an issue.
  logic [31:0] mem_words [0:63];
  logic [5:0]  rd_idx;
  int          busy_cnt;
  logic        stall_busy;
  logic        mem_clr;

  assign mem_busy = (busy_cnt != 0) || stall_busy;
  assign mem_dout = mem_words[rd_idx];

  always @(posedge clk) begin
    if (mem_clr) begin
      busy_cnt <= 0;
      rd_idx   <= 6'd0;
      for (int k = 0; k < 64; k++) mem_words[k] <= 32'h0;
    end else begin
      if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
      if (!mem_busy && (mem_re || mem_we != 4'b0000)) begin
        busy_cnt <= 3;
        rd_idx   <= mem_addr[5:0];
        for (int k = 0; k < 4; k++)
          if (mem_we[k]) mem_words[mem_addr[5:0]][8*k +: 8] <= mem_din[8*k +: 8];
      end
    end
  end

  // Reference memory, byte addressed, 256 bytes (aliases like the word array).
  logic [7:0] ref_mem [0:255];

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall;
    logic        err;
    logic [3:0]  be;
    logic [31:0] din;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [0:22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic ref_predict(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic exp_err,
                             output logic [3:0] exp_be, output logic [31:0] exp_din,
                             output logic [31:0] exp_rdata);
    int n;
    logic legal;
    logic [31:0] val;
    logic [7:0] idx;
    n = 1 << f3[1:0];
    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && !(f3[2] && we) &&
            ((addr & 32'(n - 1)) == 32'h0);
    exp_err = !legal;
    exp_be = 4'b0000;
    exp_din = 32'h0;
    exp_rdata = 32'h0;
    if (legal && we) begin
      for (int i = 0; i < n; i++) exp_be[int'(addr[1:0]) + i] = 1'b1;
      for (int k = 0; k < 4; k++) exp_din[8*k +: 8] = wdata[8*(k % n) +: 8];
    end
    if (legal && !we) begin
      val = 32'h0;
      for (int i = 0; i < n; i++) begin
        idx = addr[7:0] + 8'(i);
        val = val | (32'(ref_mem[idx]) << (8 * i));
      end
      if (!f3[2] && n < 4 && val[8*n-1]) val = val | (32'hFFFFFFFF << (8 * n));
      exp_rdata = val;
    end
  endtask

  task automatic ref_commit(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata);
    logic e;
    logic [3:0] b;
    logic [31:0] d, r;
    logic [7:0] idx;
    ref_predict(we, f3, addr, wdata, e, b, d, r);
    if (!e && we)
      for (int i = 0; i < (1 << f3[1:0]); i++) begin
        idx = addr[7:0] + 8'(i);
        ref_mem[idx] = wdata[8*i +: 8];
      end
  endtask

  // Starts at #1 after a rising edge with the DUT idle; returns the same way.
  task automatic run_txn(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                         input logic exp_err, input logic [3:0] exp_be,
                         input logic [31:0] exp_din, input logic [31:0] exp_rdata);
    int c, issue_n, issue_cyc, resp_cyc;
    logic ready_bad, busy_viol, addr_bad, got_re, got_err;
    logic [3:0] got_be;
    logic [31:0] got_din, got_maddr, got_rdata;
    c = 0; issue_n = 0; issue_cyc = -1; resp_cyc = -1;
    ready_bad = 0; busy_viol = 0; addr_bad = 0; got_re = 0; got_err = 0;
    got_be = 0; got_din = 0; got_maddr = 0; got_rdata = 0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    stall_busy = 1'b0;
    @(negedge clk);
    check({tag, " accept_ready"}, 32'(req_ready), 32'd1);
    while (c < 60 && resp_cyc < 0) begin
      @(posedge clk); #1;
      c++;
      stall_busy = (c <= stall);
      // Noise on the request port while busy; it must be ignored.
      req_valid = 1'($urandom_range(0, 1));
      req_we = 1'($urandom_range(0, 1));
      req_funct3 = 3'($urandom_range(0, 7));
      req_addr = $urandom;
      req_wdata = $urandom;
      @(negedge clk);
      if (req_ready) ready_bad = 1;
      if (mem_busy && (mem_re || mem_we != 4'b0000)) busy_viol = 1;
      if (mem_re || mem_we != 4'b0000) begin
        issue_n++; issue_cyc = c;
        got_be = mem_we; got_re = mem_re; got_din = mem_din; got_maddr = mem_addr;
      end
      if (resp_valid) begin
        resp_cyc = c; got_rdata = resp_rdata; got_err = resp_err;
      end else if (!exp_err && mem_addr !== (addr >> 2)) begin
        addr_bad = 1;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0; stall_busy = 1'b0;
    check({tag, " ready_low_while_busy"}, 32'(ready_bad), 32'd0);
    check({tag, " issue_count"}, 32'(issue_n), exp_err ? 32'd0 : 32'd1);
    check({tag, " issue_while_busy"}, 32'(busy_viol), 32'd0);
    if (!exp_err) begin
      check({tag, " issue_cycle"}, 32'(issue_cyc), 32'(1 + stall));
      check({tag, " mem_we"}, 32'(got_be), 32'(exp_be));
      check({tag, " mem_re"}, 32'(got_re), 32'(!we));
      check({tag, " mem_addr"}, got_maddr, addr >> 2);
      check({tag, " mem_addr_hold"}, 32'(addr_bad), 32'd0);
      if (we) check({tag, " mem_din"}, got_din, exp_din);
    end
    check({tag, " resp_cycle"}, 32'(resp_cyc), exp_err ? 32'd1 : 32'(6 + stall));
    check({tag, " resp_rdata"}, got_rdata, exp_rdata);
    check({tag, " resp_err"}, 32'(got_err), 32'(exp_err));
    @(negedge clk);
    check({tag, " single_pulse"}, 32'(resp_valid), 32'd0);
    check({tag, " ready_after_resp"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    ref_commit(we, f3, addr, wdata);
    $display("txn %s we=%0d f3=%0d addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0d cyc=%0d",
             tag, we, f3, addr, wdata, got_rdata, got_err, resp_cyc);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation timed out, 0 of 1 expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc_n, resp_n, acc_cyc[2], resp_cyc[2], pulses;
    logic rdy_bad;
    logic [31:0] resp_dat[2];
    logic we, e;
    logic [2:0] f3;
    logic [31:0] addr, wdata, d, r;
    logic [3:0] b;
    logic [2:0] legal_f3 [0:4];

    //             we    f3     addr      wdata          st err be     din            rdata
    vecs[0]  = '{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 1'b0, 4'hF, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 3'd2, 32'h10, 32'h0,        0, 1'b0, 4'h0, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{1'b1, 3'd0, 32'h13, 32'h80,       0, 1'b0, 4'h8, 32'h80808080, 32'h0};
    vecs[3]  = '{1'b0, 3'd0, 32'h13, 32'h0,        0, 1'b0, 4'h0, 32'h0,        32'hFFFFFF80};
    vecs[4]  = '{1'b0, 3'd4, 32'h13, 32'h0,        0, 1'b0, 4'h0, 32'h0,        32'h00000080};
    vecs[5]  = '{1'b1, 3'd1, 32'h22, 32'h1234,     0, 1'b0, 4'hC, 32'h12341234, 32'h0};
    vecs[6]  = '{1'b0, 3'd1, 32'h22, 32'h0,        0, 1'b0, 4'h0, 32'h0,        32'h00001234};
    vecs[7]  = '{1'b0, 3'd2, 32'h06, 32'h0,        0, 1'b1, 4'h0, 32'h0,        32'h0};
    vecs[8]  = '{1'b0, 3'd1, 32'h05, 32'h0,        0, 1'b1, 4'h0, 32'h0,        32'h0};
    vecs[9]  = '{1'b1, 3'd4, 32'h30, 32'hAA,       0, 1'b1, 4'h0, 32'h0,        32'h0};
    vecs[10] = '{1'b0, 3'd3, 32'h40, 32'h0,        0, 1'b1, 4'h0, 32'h0,        32'h0};
    vecs[11] = '{1'b0, 3'd2, 32'h10, 32'h0,        2, 1'b0, 4'h0, 32'h0,        32'h80ADBEEF};
    vecs[12] = '{1'b0, 3'd5, 32'h12, 32'h0,        1, 1'b0, 4'h0, 32'h0,        32'h000080AD};
    vecs[13] = '{1'b0, 3'd1, 32'h12, 32'h0,        0, 1'b0, 4'h0, 32'h0,        32'hFFFF80AD};
    vecs[14] = '{1'b0, 3'd0, 32'h10, 32'h0,        0, 1'b0, 4'h0, 32'h0,        32'hFFFFFFEF};
    vecs[15] = '{1'b1, 3'd5, 32'h20, 32'h5555,     0, 1'b1, 4'h0, 32'h0,        32'h0};
    vecs[16] = '{1'b1, 3'd2, 32'h21, 32'h11223344, 0, 1'b1, 4'h0, 32'h0,        32'h0};
    vecs[17] = '{1'b1, 3'd1, 32'h2A, 32'hBEEF,     3, 1'b0, 4'hC, 32'hBEEFBEEF, 32'h0};
    vecs[18] = '{1'b0, 3'd0, 32'h2B, 32'h0,        0, 1'b0, 4'h0, 32'h0,        32'hFFFFFFBE};
    vecs[19] = '{1'b0, 3'd5, 32'h2A, 32'h0,        0, 1'b0, 4'h0, 32'h0,        32'h0000BEEF};
    vecs[20] = '{1'b1, 3'd0, 32'h01, 32'h7F,       0, 1'b0, 4'h2, 32'h7F7F7F7F, 32'h0};
    vecs[21] = '{1'b0, 3'd0, 32'h01, 32'h0,        0, 1'b0, 4'h0, 32'h0,        32'h0000007F};
    vecs[22] = '{1'b0, 3'd2, 32'h00, 32'h0,        0, 1'b0, 4'h0, 32'h0,        32'h00007F00};

    legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2;
    legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;
    for (int k = 0; k < 256; k++) ref_mem[k] = 8'h00;

    rstn = 1'b0; mem_clr = 1'b1; stall_busy = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset resp_rdata", resp_rdata, 32'h0);
    check("reset resp_err", 32'(resp_err), 32'd0);
    check("reset mem_we", 32'(mem_we), 32'd0);
    check("reset mem_re", 32'(mem_re), 32'd0);
    check("reset mem_addr", mem_addr, 32'h0);
    check("reset mem_din", mem_din, 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1; mem_clr = 1'b0;
    @(negedge clk);
    check("reset req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 23; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
              vecs[i].stall, vecs[i].err, vecs[i].be, vecs[i].din, vecs[i].rdata);

    // Back-to-back: req_valid held high. The request changes to LW 0x20
    // mid-access; that must not disturb the first access.
    acc_n = 0; resp_n = 0; rdy_bad = 0;
    acc_cyc[0] = -1; acc_cyc[1] = -1; resp_cyc[0] = -1; resp_cyc[1] = -1;
    resp_dat[0] = 32'h0; resp_dat[1] = 32'h0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10; req_wdata = 32'h0;
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      if (req_valid && req_ready && acc_n < 2) begin acc_cyc[acc_n] = c; acc_n++; end
      if (((c >= 1 && c <= 6) || (c >= 8 && c <= 13)) && req_ready) rdy_bad = 1;
      if (resp_valid && resp_n < 2) begin
        resp_cyc[resp_n] = c; resp_dat[resp_n] = resp_rdata; resp_n++;
      end
      @(posedge clk); #1;
      if (c + 1 == 3) req_addr = 32'h20;
      if (acc_n == 2) req_valid = 1'b0;
    end
    check("b2b accepts", 32'(acc_n), 32'd2);
    check("b2b accept0_cycle", 32'(acc_cyc[0]), 32'd0);
    check("b2b accept1_cycle", 32'(acc_cyc[1]), 32'd7);
    check("b2b resp0_cycle", 32'(resp_cyc[0]), 32'd6);
    check("b2b resp0_rdata", resp_dat[0], 32'h80ADBEEF);
    check("b2b resp1_cycle", 32'(resp_cyc[1]), 32'd13);
    check("b2b resp1_rdata", resp_dat[1], 32'h12340000);
    check("b2b ready_low", 32'(rdy_bad), 32'd0);
    $display("txn b2b accepts=%0d at %0d,%0d resps at %0d,%0d data 0x%08h 0x%08h",
             acc_n, acc_cyc[0], acc_cyc[1], resp_cyc[0], resp_cyc[1], resp_dat[0], resp_dat[1]);

    // Reset while in WAIT aborts the load without a response.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("wait_rst resp_valid", 32'(resp_valid), 32'd0);
    check("wait_rst resp_rdata", resp_rdata, 32'h0);
    check("wait_rst resp_err", 32'(resp_err), 32'd0);
    check("wait_rst mem_we", 32'(mem_we), 32'd0);
    check("wait_rst mem_re", 32'(mem_re), 32'd0);
    check("wait_rst mem_addr", mem_addr, 32'h0);
    check("wait_rst mem_din", mem_din, 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check("wait_rst ready_after", 32'(req_ready), 32'd1);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      if (resp_valid) pulses++;
      @(negedge clk);
    end
    check("wait_rst no_resp", 32'(pulses), 32'd0);
    @(posedge clk); #1;
    $display("txn wait_rst aborted, stray pulses=%0d", pulses);
    run_txn("post_rst_lw", 1'b0, 3'd2, 32'h10, 32'h0, 0, 1'b0, 4'h0, 32'h0, 32'h80ADBEEF);

    // Randomized accesses against the byte-level reference model.
    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = ($urandom_range(0, 3) != 0) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      addr = ($urandom & 32'hFFFFFF00) | 32'($urandom_range(0, 255));
      if ($urandom_range(0, 2) != 0) addr = addr & ~(32'h1 << $urandom_range(0, 1));
      wdata = $urandom;
      ref_predict(we, f3, addr, wdata, e, b, d, r);
      run_txn($sformatf("rnd%0d", i), we, f3, addr, wdata, $urandom_range(0, 3), e, b, d, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
